// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue in front of the MIPS32 IF stage: req/ack fetch, {IR, NPC} FIFO, branch flush.
// Optional macro FETCHQ_BYPASS_EN: a transfer into an empty queue is presented on deq_* in the same cycle.
module mips32_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                   clk1,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [AW-1:0]          imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    input  logic                   halt,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_ir,
    output logic [AW-1:0]          deq_npc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic          r_req;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_fpc;
    logic          r_drop;
    logic [31:0]   r_ir  [DEPTH];
    logic [AW-1:0] r_npc [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    logic          w_xfer;
    logic [AW-1:0] w_npc;
    logic          w_empty;
    logic          w_byp;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cnt_next;
    logic          w_issue;
    logic [AW-1:0] w_fpc_next;

    assign w_xfer  = r_req & imem_ack;
    assign w_npc   = r_addr + AW'(1);
    assign w_empty = (r_cnt == '0);

`ifdef FETCHQ_BYPASS_EN
    assign w_byp     = w_empty & ~r_drop & ~redirect & w_xfer;
    assign deq_valid = ~w_empty | w_byp;
    assign deq_ir    = w_byp ? imem_rdata : r_ir[r_rp];
    assign deq_npc   = w_byp ? w_npc : r_npc[r_rp];
`else
    assign w_byp     = 1'b0;
    assign deq_valid = ~w_empty;
    assign deq_ir    = r_ir[r_rp];
    assign deq_npc   = r_npc[r_rp];
`endif

    // A bypassed word that the consumer takes is never written to the FIFO.
    assign w_push = w_xfer & ~r_drop & ~redirect & ~(w_byp & deq_ready);
    assign w_pop  = ~w_empty & deq_ready & ~redirect;

    always_comb begin
        w_cnt_next = r_cnt;
        if (redirect) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign w_fpc_next = w_xfer ? w_npc : r_fpc;
    assign w_issue    = (~r_req | w_xfer) & ~halt & ~redirect & ~r_drop & (w_cnt_next < FULL);

    // While drop is set, fpc already holds the redirect target; the discarded transfer must not advance it.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_req  <= 1'b0;
            r_addr <= '0;
            r_fpc  <= '0;
            r_drop <= 1'b0;
        end else begin
            if (redirect) begin
                r_fpc  <= redirect_pc;
                r_drop <= r_req & ~w_xfer;
            end else if (w_xfer) begin
                r_drop <= 1'b0;
                if (!r_drop) begin
                    r_fpc <= w_npc;
                end
            end
            if (w_issue) begin
                r_req  <= 1'b1;
                r_addr <= w_fpc_next;
            end else if (w_xfer) begin
                r_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_ir  <= '{default: '0};
            r_npc <= '{default: '0};
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (redirect) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_ir[r_wp]  <= imem_rdata;
                r_npc[r_wp] <= w_npc;
                r_wp        <= r_wp + PW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PW'(1);
            end
            r_cnt <= w_cnt_next;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign count     = r_cnt;

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Self-checking bench for mips32_fetch_queue: reset/fill-drain vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model (honours FETCHQ_BYPASS_EN).
module tb_mips32_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_ir;
    logic [31:0] deq_npc;
    logic [2:0]  count;

    mips32_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_ir(deq_ir), .deq_npc(deq_npc),
        .count(count)
    );

    always #5 clk1 = ~clk1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: outstanding request, fetch pointer, pending target and a queue of {ir, npc}.
    logic [63:0] m_q[$];
    logic        m_req;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_fpc;
    logic [31:0] m_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; halt = 1'b0; imem_ack = 1'b0; deq_ready = 1'b0;
        m_q.delete(); m_req = 1'b0; m_drop = 1'b0; m_addr = '0; m_fpc = '0; m_tgt = '0;
        @(negedge clk1);
        @(negedge clk1);
        #1;
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_addr",  imem_addr,      32'd0);
        chk("rst_valid", 32'(deq_valid), 32'd0);
        chk("rst_ir",    deq_ir,         32'd0);
        chk("rst_npc",   deq_npc,        32'd0);
        chk("rst_count", 32'(count),     32'd0);
        rst_n = 1'b1;
    endtask

    // Drive one cycle's inputs (called just after a falling edge) and compare against the model.
    task automatic drv_chk(input logic ack, input logic [31:0] rdata, input logic rdy,
                           input logic hlt, input logic rd, input logic [31:0] rpc);
        logic        xfer, byp, ev;
        logic [63:0] head;
        imem_ack = ack; imem_rdata = rdata; deq_ready = rdy; halt = hlt; redirect = rd; redirect_pc = rpc;
        #1;
        xfer = m_req && ack;
        byp  = BYP && (m_q.size() == 0) && !m_drop && !rd && xfer;
        ev   = (m_q.size() != 0) || byp;
        head = '0;
        if (byp) head = {rdata, m_addr + 32'd1};
        else if (m_q.size() != 0) head = m_q[0];
        chk("imem_req",  32'(imem_req),  32'(m_req));
        chk("imem_addr", imem_addr,      m_addr);
        chk("deq_valid", 32'(deq_valid), 32'(ev));
        chk("count",     32'(count),     32'(m_q.size()));
        if (ev) begin
            chk("deq_ir",  deq_ir,  head[63:32]);
            chk("deq_npc", deq_npc, head[31:0]);
        end
    endtask

    // Advance the model across the rising edge using the currently driven inputs.
    task automatic adv();
        logic xfer, byp, blocked;
        xfer    = m_req && imem_ack;
        byp     = BYP && (m_q.size() == 0) && !m_drop && !redirect && xfer;
        blocked = m_drop;
        if (redirect) begin
            m_q.delete();
            if (m_req && !xfer) begin
                m_drop = 1'b1;
                m_tgt  = redirect_pc;
            end else begin
                m_drop = 1'b0;
                m_fpc  = redirect_pc;
            end
            if (xfer) m_req = 1'b0;
        end else begin
            if (m_q.size() != 0 && deq_ready) void'(m_q.pop_front());
            if (xfer) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                    m_fpc  = m_tgt;
                end else begin
                    m_fpc = m_addr + 32'd1;
                    if (!(byp && deq_ready)) m_q.push_back({imem_rdata, m_fpc});
                end
                m_req = 1'b0;
            end
            if (!m_req && !halt && !blocked && (m_q.size() < DEPTH)) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end
        @(negedge clk1);
    endtask

    task automatic cyc(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic hlt, input logic rd, input logic [31:0] rpc);
        drv_chk(ack, rdata, rdy, hlt, rd, rpc);
        adv();
    endtask

    typedef struct {
        logic        ack;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [2:0]  e_cnt;
        logic        e_valid;
        logic [31:0] e_ir;
        logic [31:0] e_npc;
    } vec_t;

    vec_t vt[11];

    initial begin
        // Fill with consumer stalled, then drain with consumer ready; rdata = 0x1000_0000 + addr.
        vt[0]  = '{1'b1, 1'b0, 32'h1000_0000, 1'b0, 32'd0, 3'd0, 1'b0, 32'h0,         32'd0};
        vt[1]  = '{1'b1, 1'b0, 32'h1000_0000, 1'b1, 32'd0, 3'd0, 1'b0, 32'h0,         32'd0};
        vt[2]  = '{1'b1, 1'b0, 32'h1000_0001, 1'b1, 32'd1, 3'd1, 1'b1, 32'h1000_0000, 32'd1};
        vt[3]  = '{1'b1, 1'b0, 32'h1000_0002, 1'b1, 32'd2, 3'd2, 1'b1, 32'h1000_0000, 32'd1};
        vt[4]  = '{1'b1, 1'b0, 32'h1000_0003, 1'b1, 32'd3, 3'd3, 1'b1, 32'h1000_0000, 32'd1};
        vt[5]  = '{1'b1, 1'b0, 32'h1000_0003, 1'b0, 32'd3, 3'd4, 1'b1, 32'h1000_0000, 32'd1};
        vt[6]  = '{1'b1, 1'b1, 32'h1000_0003, 1'b0, 32'd3, 3'd4, 1'b1, 32'h1000_0000, 32'd1};
        vt[7]  = '{1'b1, 1'b1, 32'h1000_0004, 1'b1, 32'd4, 3'd3, 1'b1, 32'h1000_0001, 32'd2};
        vt[8]  = '{1'b1, 1'b1, 32'h1000_0005, 1'b1, 32'd5, 3'd3, 1'b1, 32'h1000_0002, 32'd3};
        vt[9]  = '{1'b1, 1'b1, 32'h1000_0006, 1'b1, 32'd6, 3'd3, 1'b1, 32'h1000_0003, 32'd4};
        vt[10] = '{1'b1, 1'b1, 32'h1000_0007, 1'b1, 32'd7, 3'd3, 1'b1, 32'h1000_0004, 32'd5};

        @(negedge clk1);
        do_reset();
        for (int i = 0; i < 11; i++) begin
            logic        ev;
            logic [31:0] eir, enpc;
            imem_ack = vt[i].ack; deq_ready = vt[i].rdy; imem_rdata = vt[i].rdata;
            halt = 1'b0; redirect = 1'b0;
            #1;
            ev = vt[i].e_valid; eir = vt[i].e_ir; enpc = vt[i].e_npc;
            if (BYP && vt[i].e_cnt == 3'd0 && vt[i].e_req && vt[i].ack) begin
                ev = 1'b1; eir = vt[i].rdata; enpc = vt[i].e_addr + 32'd1;
            end
            chk("tbl_req",   32'(imem_req),  32'(vt[i].e_req));
            chk("tbl_addr",  imem_addr,      vt[i].e_addr);
            chk("tbl_count", 32'(count),     32'(vt[i].e_cnt));
            chk("tbl_valid", 32'(deq_valid), 32'(ev));
            if (ev) begin
                chk("tbl_ir",  deq_ir,  eir);
                chk("tbl_npc", deq_npc, enpc);
            end
            @(negedge clk1);
        end

        // Stalled memory at addr 2 with halt pulsed mid-stall.
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            drv_chk(1'b0, 32'hEE, 1'b0, (i == 2 || i == 3), 1'b0, '0);
            chk("stall_addr", imem_addr, 32'd2);
            chk("stall_req",  32'(imem_req), 32'd1);
            adv();
        end
        cyc(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, '0);
        chk("stall_count", 32'(count), 32'd3);

        // Redirect with nothing pending.
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hB1, 1'b0, 1'b1, 1'b0, '0);
        chk("rdn_pre_count", 32'(count), 32'd2);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h40);
        chk("rdn_count", 32'(count), 32'd0);
        chk("rdn_valid", 32'(deq_valid), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("rdn_addr", imem_addr, 32'h40);
        cyc(1'b1, 32'hB40, 1'b0, 1'b0, 1'b0, '0);
        chk("rdn_npc", deq_npc, 32'h41);

        // Redirect while a request to addr 7 is held.
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'd7);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("rdp_addr7", imem_addr, 32'd7);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h20);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hBAD0_0007, 1'b1, 1'b0, 1'b0, '0);
        chk("rdp_count", 32'(count), 32'd0);
        chk("rdp_req",   32'(imem_req), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("rdp_newaddr", imem_addr, 32'h20);
        cyc(1'b1, 32'hC20, 1'b0, 1'b0, 1'b0, '0);
        chk("rdp_npc", deq_npc, 32'h21);

        // Simultaneous enqueue/dequeue, then redirect with transfer and pop together.
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hD0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hD2, 1'b1, 1'b0, 1'b0, '0);
        chk("sim_count", 32'(count), 32'd2);
        cyc(1'b1, 32'hD3, 1'b1, 1'b0, 1'b1, 32'h80);
        chk("sim_flush_count", 32'(count), 32'd0);
        chk("sim_flush_valid", 32'(deq_valid), 32'd0);

        // Fetch at the top of the address space: NPC wraps to 0.
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'hF00D, 1'b0, 1'b0, 1'b0, '0);
        chk("wrap_npc",  deq_npc,   32'd0);
        chk("wrap_addr", imem_addr, 32'd0);

        // Transfer into an empty queue at addr 9.
        do_reset();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'd9);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
`ifdef FETCHQ_BYPASS_EN
        drv_chk(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, '0);
        chk("byp_valid", 32'(deq_valid), 32'd1);
        chk("byp_ir",    deq_ir,  32'hDEAD_BEEF);
        chk("byp_npc",   deq_npc, 32'd10);
        adv();
        chk("byp_count", 32'(count), 32'd0);
`else
        drv_chk(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, '0);
        chk("lat_valid0", 32'(deq_valid), 32'd0);
        adv();
        chk("lat_valid1", 32'(deq_valid), 32'd1);
        chk("lat_ir",     deq_ir,  32'hDEAD_BEEF);
        chk("lat_npc",    deq_npc, 32'd10);
        chk("lat_count",  32'(count), 32'd1);
`endif

        // Randomized traffic with periodic mid-transaction resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int unsigned lvl;
            lvl = (i / 150) % 4;
            if (i % 700 == 699) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) < lvl,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
